// File: rtl/skid_buffer.sv
// skid_buffer: valid/ready pipeline stage with a two-entry skid register.
//
// Sits directly upstream of enable-gated register stages. It carries
// one word per cycle, and under back-pressure it neither drops nor
// duplicates words. Every handshake output is taken straight from a
// register, so there is no combinational path from out_ready to
// in_ready.
//
// Parameters:
//   size      - data width in bits (>= 1)
//
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous reset, active low
//   flush     - synchronous discard of all held words, active high
//   in_valid  - upstream word present
//   in_ready  - stage can accept a word this cycle
//   in_data   - upstream word
//   out_valid - main register holds a word
//   out_ready - downstream accepts out_data this cycle
//   out_data  - word in main register
//   count     - words held (0, 1 or 2)
module skid_buffer #(
    parameter int unsigned size = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [size-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [size-1:0] out_data,
    output logic [1:0]      count
);

    logic [size-1:0] r_main_q;
    logic            r_main_v;
    logic [size-1:0] r_skid_q;
    logic            r_skid_v;

    logic w_in_fire;
    logic w_out_fire;

    assign w_in_fire  = in_valid & ~r_skid_v;
    assign w_out_fire = r_main_v & out_ready;

    assign in_ready  = ~r_skid_v;
    assign out_valid = r_main_v;
    assign out_data  = r_main_q;
    assign count     = {1'b0, r_main_v} + {1'b0, r_skid_v};

    // Occupancy is encoded by the two valid bits: main only -> BUSY,
    // both -> FULL, neither -> EMPTY. The skid entry is only ever
    // filled behind a valid main entry, so it always holds the younger
    // word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_main_q <= '0;
            r_main_v <= 1'b0;
            r_skid_q <= '0;
            r_skid_v <= 1'b0;
        end else if (flush) begin
            // Data registers keep their contents. Only the valid bits are dropped.
            r_main_v <= 1'b0;
            r_skid_v <= 1'b0;
        end else if (!r_main_v) begin
            // EMPTY
            if (w_in_fire) begin
                r_main_q <= in_data;
                r_main_v <= 1'b1;
            end
        end else if (!r_skid_v) begin
            // BUSY
            if (w_in_fire && w_out_fire) begin
                r_main_q <= in_data;
            end else if (w_in_fire) begin
                r_skid_q <= in_data;
                r_skid_v <= 1'b1;
            end else if (w_out_fire) begin
                r_main_v <= 1'b0;
            end
        end else begin
            // FULL: in_ready is low, so the only possible event is a drain
            // of main. When that happens, the skid word moves up into main.
            if (w_out_fire) begin
                r_main_q <= r_skid_q;
                r_skid_v <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_skid_buffer.sv
// Self-checking bench for skid_buffer. It drives three instances
// (size = 8, 1, 64) with one shared handshake stream, so handshake
// timing must be identical across widths. Each instance is compared
// against a FIFO-of-depth-2 reference model.
module tb_skid_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [63:0] in_data64;

    logic        in_ready8,  out_valid8;
    logic [7:0]  out_data8;
    logic [1:0]  count8;
    logic        in_ready1,  out_valid1;
    logic [0:0]  out_data1;
    logic [1:0]  count1;
    logic        in_ready64, out_valid64;
    logic [63:0] out_data64;
    logic [1:0]  count64;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    skid_buffer #(.size(8)) u_dut8 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready8), .in_data(in_data64[7:0]),
        .out_valid(out_valid8), .out_ready(out_ready), .out_data(out_data8),
        .count(count8)
    );

    skid_buffer #(.size(1)) u_dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data64[0:0]),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .count(count1)
    );

    skid_buffer #(.size(64)) u_dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64), .in_data(in_data64),
        .out_valid(out_valid64), .out_ready(out_ready), .out_data(out_data64),
        .count(count64)
    );

    // Reference model: the ordered list of words currently held.
    logic [63:0] mq[$];
    logic        last_push;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [63:0] head;
        logic        v;
        v    = (mq.size() > 0);
        head = v ? mq[0] : 64'd0;
        chk("out_valid8",  {63'd0, out_valid8},  {63'd0, v});
        chk("out_valid1",  {63'd0, out_valid1},  {63'd0, v});
        chk("out_valid64", {63'd0, out_valid64}, {63'd0, v});
        chk("in_ready8",   {63'd0, in_ready8},   {63'd0, mq.size() < 2});
        chk("in_ready1",   {63'd0, in_ready1},   {63'd0, mq.size() < 2});
        chk("in_ready64",  {63'd0, in_ready64},  {63'd0, mq.size() < 2});
        chk("count8",      {62'd0, count8},      64'(mq.size()));
        chk("count1",      {62'd0, count1},      64'(mq.size()));
        chk("count64",     {62'd0, count64},     64'(mq.size()));
        if (v) begin
            chk("out_data8",  {56'd0, out_data8}, {56'd0, head[7:0]});
            chk("out_data1",  {63'd0, out_data1}, {63'd0, head[0]});
            chk("out_data64", out_data64, head);
        end
    endtask

    // Checks the state-derived outputs, then advances one clock. The model
    // is updated from the inputs that the DUTs sample at that edge.
    task automatic cycle();
        logic        pop, push;
        logic        stall;
        logic [63:0] held;
        check_outputs();
        stall = out_valid64 && !out_ready && !flush;
        held  = out_data64;
        pop   = (mq.size() > 0) && out_ready;
        push  = in_valid && (mq.size() < 2);
        @(posedge clk);
        #1;
        if (flush) begin
            mq.delete();
            last_push = 1'b0;
        end else begin
            if (pop)  void'(mq.pop_front());
            if (push) mq.push_back(in_data64);
            last_push = push;
        end
        if (stall) chk("stall_stable64", out_data64, held);
    endtask

    task automatic drive(input logic fl, input logic iv, input logic [63:0] d, input logic ordy);
        flush     = fl;
        in_valid  = iv;
        in_data64 = d;
        out_ready = ordy;
    endtask

    typedef struct {
        logic       fl;
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic       ev;
        logic [7:0] ed;
        logic       er;
        logic [1:0] ec;
    } vec_t;

    vec_t tbl[12];

    initial begin
        // Back-pressure: the rows give the inputs before an edge and the
        // outputs expected after it.
        tbl[0]  = '{1'b0, 1'b1, 8'hA1, 1'b0, 1'b1, 8'hA1, 1'b1, 2'd1};
        tbl[1]  = '{1'b0, 1'b1, 8'hA2, 1'b0, 1'b1, 8'hA1, 1'b0, 2'd2};
        tbl[2]  = '{1'b0, 1'b1, 8'hA3, 1'b0, 1'b1, 8'hA1, 1'b0, 2'd2};
        tbl[3]  = '{1'b0, 1'b1, 8'hA3, 1'b1, 1'b1, 8'hA2, 1'b1, 2'd1};
        tbl[4]  = '{1'b0, 1'b1, 8'hA3, 1'b1, 1'b1, 8'hA3, 1'b1, 2'd1};
        tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 2'd0};
        // Flush: a FULL stage with a word offered during the flush cycle.
        tbl[6]  = '{1'b0, 1'b1, 8'h55, 1'b0, 1'b1, 8'h55, 1'b1, 2'd1};
        tbl[7]  = '{1'b0, 1'b1, 8'h66, 1'b0, 1'b1, 8'h55, 1'b0, 2'd2};
        tbl[8]  = '{1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 8'h00, 1'b1, 2'd0};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 2'd0};
        tbl[10] = '{1'b0, 1'b1, 8'h88, 1'b1, 1'b1, 8'h88, 1'b1, 2'd1};
        tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 2'd0};

        last_push = 1'b0;
        rst = 1'b0;
        drive(1'b0, 1'b0, 64'd0, 1'b0);
        #1;
        check_outputs();
        chk("rst_out_data64", out_data64, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Streaming at one word per cycle with a 1-cycle latency.
        for (int i = 1; i <= 16; i++) begin
            drive(1'b0, 1'b1, 64'(i), 1'b1);
            cycle();
            chk("stream_data8", {56'd0, out_data8}, 64'(i));
            chk("stream_ready8", {63'd0, in_ready8}, 64'd1);
            chk("stream_cnt_le1", {63'd0, count8 <= 2'd1}, 64'd1);
        end
        drive(1'b0, 1'b0, 64'd0, 1'b1);
        cycle();

        // Table-driven vectors.
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].fl, tbl[i].iv, {8{tbl[i].d}}, tbl[i].ordy);
            cycle();
            chk("tbl_valid", {63'd0, out_valid8}, {63'd0, tbl[i].ev});
            chk("tbl_ready", {63'd0, in_ready8},  {63'd0, tbl[i].er});
            chk("tbl_count", {62'd0, count8},     {62'd0, tbl[i].ec});
            if (tbl[i].ev) chk("tbl_data", {56'd0, out_data8}, {56'd0, tbl[i].ed});
        end

        // Width extremes: alternating all-ones/all-zeros under back-pressure.
        for (int i = 0; i < 48; i++) begin
            if (!(in_valid && !last_push))
                drive(1'b0, 1'b1, (i % 2 == 0) ? '1 : '0, 1'b0);
            out_ready = (i % 3 == 2);
            cycle();
        end
        drive(1'b0, 1'b0, 64'd0, 1'b1);
        cycle();
        cycle();

        // Random stall. The source holds an offer until it is accepted.
        for (int i = 0; i < 2000; i++) begin
            if (!(in_valid && !last_push && !flush)) begin
                in_valid  = ($urandom_range(0, 2) != 0);
                in_data64 = {$urandom, $urandom};
            end
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 127) == 0);
            cycle();
            chk("count_lt3", {63'd0, count64 != 2'd3}, 64'd1);
        end

        // Asynchronous reset asserted mid-stream while FULL holds 0x11/0x22.
        drive(1'b1, 1'b0, 64'd0, 1'b0);
        cycle();
        drive(1'b0, 1'b1, {8{8'h11}}, 1'b0);
        cycle();
        drive(1'b0, 1'b1, {8{8'h22}}, 1'b0);
        cycle();
        chk("pre_rst_count8", {62'd0, count8}, 64'd2);
        #2;
        rst = 1'b0;
        #1;
        mq.delete();
        chk("rst_valid8", {63'd0, out_valid8}, 64'd0);
        chk("rst_data8",  {56'd0, out_data8},  64'd0);
        chk("rst_ready8", {63'd0, in_ready8},  64'd1);
        chk("rst_count8", {62'd0, count8},     64'd0);
        chk("rst_data64", out_data64, 64'd0);
        check_outputs();
        drive(1'b0, 1'b0, 64'd0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_outputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
